// File: rtl/msg_assembler_pkg.sv
// Shared definitions for the message assembler: default widths, FSM state
// encoding and the character constants it recognises.
// Optional feature macro: MSG_ASSEMBLER_TERM_EN (CR-terminated messages).
package msg_pkg;

  localparam int N_DEFAULT = 8;
  localparam int M_DEFAULT = 128;

  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_PAD = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1
`ifdef MSG_ASSEMBLER_TERM_EN
    ,
    ST_PAD     = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/msg_assembler_if.sv
// Character-in / message-out bundle for msg_assembler.
// master: UART RX side plus message consumer; slave: the assembler itself.
interface msg_assembler_if #(
  parameter int N = msg_pkg::N_DEFAULT,
  parameter int M = msg_pkg::M_DEFAULT
);
  localparam int CW = $clog2(M / N) + 1;

  logic          rx_valid;
  logic [N-1:0]  rx_data;
  logic [M-1:0]  msg;
  logic          msg_valid;
  logic [CW-1:0] count;
  logic          overrun;

  modport master (
    output rx_valid,
    output rx_data,
    input  msg,
    input  msg_valid,
    input  count,
    input  overrun
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output msg,
    output msg_valid,
    output count,
    output overrun
  );
endinterface

// File: rtl/msg_assembler.sv
// Packs received characters MSB-first into an M-bit message and publishes
// each completed message with a one-cycle msg_valid pulse.
// Optional feature macro: MSG_ASSEMBLER_TERM_EN -- CR ends a message early
// (remaining slots padded with spaces), LF is discarded.
module msg_assembler
  import msg_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int M = M_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  msg_assembler_if.slave bus
);
  localparam int CHARS = M / N;
  localparam int CW    = $clog2(CHARS) + 1;
  localparam logic [CW-1:0] LAST = CW'(CHARS - 1);

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [M-1:0]  buffer, buffer_n;
  logic [M-1:0]  msg, msg_n;
  logic          msg_valid, msg_valid_n;
  logic          overrun, overrun_n;

  logic          push;
  logic [N-1:0]  push_data;
  logic [M-1:0]  shifted;

  // Registered state; reset wins over any same-cycle character.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      buffer    <= '0;
      msg       <= '0;
      msg_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      buffer    <= buffer_n;
      msg       <= msg_n;
      msg_valid <= msg_valid_n;
      overrun   <= overrun_n;
    end
  end

  // Next-state logic: decide what (if anything) is written this cycle,
  // then shift it in and complete the message on the last slot.
  // The buffer shifts left, so after CHARS writes the first character
  // sits in the top slot -- same result as writing at position count.
  always_comb begin
    state_n     = state;
    count_n     = count;
    buffer_n    = buffer;
    msg_n       = msg;
    msg_valid_n = 1'b0;
    overrun_n   = overrun;
    push        = 1'b0;
    push_data   = bus.rx_data;

    case (state)
      ST_IDLE, ST_COLLECT: begin
        if (bus.rx_valid) begin
`ifdef MSG_ASSEMBLER_TERM_EN
          if (bus.rx_data == N'(CHAR_LF)) begin
            push = 1'b0;
          end else if (bus.rx_data == N'(CHAR_CR)) begin
            state_n = ST_PAD;
          end else begin
            push = 1'b1;
          end
`else
          push = 1'b1;
`endif
        end
      end
`ifdef MSG_ASSEMBLER_TERM_EN
      ST_PAD: begin
        push      = 1'b1;
        push_data = N'(CHAR_PAD);
        if (bus.rx_valid && (bus.rx_data != N'(CHAR_LF))) begin
          overrun_n = 1'b1;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase

    shifted = {buffer[M-N-1:0], push_data};

    if (push) begin
      if (count == LAST) begin
        msg_n       = shifted;
        msg_valid_n = 1'b1;
        count_n     = '0;
        buffer_n    = '0;
        state_n     = ST_IDLE;
      end else begin
        buffer_n = shifted;
        count_n  = count + 1'b1;
`ifdef MSG_ASSEMBLER_TERM_EN
        state_n  = (state == ST_PAD) ? ST_PAD : ST_COLLECT;
`else
        state_n  = ST_COLLECT;
`endif
      end
    end
  end

  assign bus.msg       = msg;
  assign bus.msg_valid = msg_valid;
  assign bus.count     = count;
  assign bus.overrun   = overrun;

endmodule

// File: tb/tb_msg_assembler.sv
// Directed self-checking bench for msg_assembler (N=8, M=128).
module tb_msg_assembler;
  localparam int N = 8;
  localparam int M = 128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;

  always #5 clk = ~clk;

  msg_assembler_if #(.N(N), .M(M)) bus ();

  msg_assembler #(.N(N), .M(M)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Count msg_valid pulses at the falling edge (outputs are stable there).
  always @(negedge clk) if (bus.msg_valid === 1'b1) pulses++;

  localparam logic [127:0] WAKE = 128'h57616B652075702C204E656F2E2E2E21;
  localparam logic [127:0] ALPHA = 128'h4142434445464748494A4B4C4D4E4F50;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one character for exactly one rising edge; returns at the
  // falling edge right after the edge that accepted it.
  task automatic send(input logic [7:0] c);
    bus.rx_valid = 1'b1;
    bus.rx_data  = c;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_wake(input int gap);
    logic [127:0] w;
    w = WAKE;
    for (int i = 0; i < 16; i++) begin
      idle(gap);
      send(w[127-8*i -: 8]);
    end
  endtask

  task automatic test_reset();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h41;
    reset = 1'b1;
    idle(3);
    checks++; if (bus.msg !== '0) begin errors++; $display("FAIL reset_msg got=%h exp=0", bus.msg); end
    checks++; if (bus.msg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.msg_valid); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    bus.rx_valid = 1'b0;
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_message();
    logic [127:0] w;
    w = WAKE;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      idle(19);
      send(w[127-8*i -: 8]);
      if (i == 4) begin
        checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL partial_count got=%0d exp=5", bus.count); end
        checks++; if (bus.msg !== '0) begin errors++; $display("FAIL partial_hidden got=%h exp=0", bus.msg); end
      end
    end
    checks++; if (bus.msg_valid !== 1'b1) begin errors++; $display("FAIL msg_valid got=%b exp=1", bus.msg_valid); end
    checks++; if (bus.msg !== WAKE) begin errors++; $display("FAIL msg got=%h exp=%h", bus.msg, WAKE); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL msg_count got=%0d exp=0", bus.count); end
    idle(1);
    checks++; if (bus.msg_valid !== 1'b0) begin errors++; $display("FAIL valid_drop got=%b exp=0", bus.msg_valid); end
    idle(2);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL msg_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] w;
    w = WAKE;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      send(w[127-8*i -: 8]);
    end
    checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL mid_count got=%0d exp=5", bus.count); end
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL mid_reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.msg !== '0) begin errors++; $display("FAIL mid_reset_msg got=%h exp=0", bus.msg); end
    send_wake(2);
    checks++; if (bus.msg !== WAKE) begin errors++; $display("FAIL mid_msg got=%h exp=%h", bus.msg, WAKE); end
    idle(2);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL mid_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] w, a;
    w = WAKE;
    a = ALPHA;
    pulses = 0;
    for (int i = 0; i < 16; i++) send(w[127-8*i -: 8]);
    checks++; if (bus.msg_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", bus.msg_valid); end
    send(a[127 -: 8]);
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL b2b_count got=%0d exp=1", bus.count); end
    for (int i = 1; i < 15; i++) send(a[127-8*i -: 8]);
    checks++; if (bus.msg !== WAKE) begin errors++; $display("FAIL b2b_hold got=%h exp=%h", bus.msg, WAKE); end
    send(a[7:0]);
    checks++; if (bus.msg !== ALPHA) begin errors++; $display("FAIL b2b_msg got=%h exp=%h", bus.msg, ALPHA); end
    idle(2);
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_strobe_hold();
    idle(3);
    pulses = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h41;
    idle(16);
    bus.rx_valid = 1'b0;
    checks++; if (bus.msg !== {16{8'h41}}) begin errors++; $display("FAIL hold_msg got=%h exp=all41", bus.msg); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL hold_count got=%0d exp=0", bus.count); end
    idle(2);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL hold_pulses got=%0d exp=1", pulses); end
  endtask

`ifdef MSG_ASSEMBLER_TERM_EN
  task automatic test_term();
    logic [127:0] exp_neo;
    exp_neo = {24'h4E656F, {13{8'h20}}};
    pulses = 0;
    send(8'h4E);
    send(8'h65);
    send(8'h0A);
    checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL lf_count got=%0d exp=2", bus.count); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL lf_overrun got=%b exp=0", bus.overrun); end
    send(8'h6F);
    send(8'h0D);
    for (int i = 0; i < 12; i++) begin
      if (i == 4) begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h58;
      end
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
    checks++; if (bus.msg_valid !== 1'b0) begin errors++; $display("FAIL pad_early got=%b exp=0", bus.msg_valid); end
    checks++; if (bus.msg !== {16{8'h41}}) begin errors++; $display("FAIL pad_hold got=%h exp=all41", bus.msg); end
    idle(1);
    checks++; if (bus.msg_valid !== 1'b1) begin errors++; $display("FAIL pad_valid got=%b exp=1", bus.msg_valid); end
    checks++; if (bus.msg !== exp_neo) begin errors++; $display("FAIL pad_msg got=%h exp=%h", bus.msg, exp_neo); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL pad_overrun got=%b exp=1", bus.overrun); end
    idle(2);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL pad_pulses got=%0d exp=1", pulses); end
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    send(8'h0D);
    idle(16);
    checks++; if (bus.msg !== {16{8'h20}}) begin errors++; $display("FAIL cr_idle got=%h exp=all20", bus.msg); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL cr_idle_overrun got=%b exp=0", bus.overrun); end
  endtask
`else
  task automatic test_cr_stored();
    logic [127:0] exp_cr;
    exp_cr = 128'h4E656F0D0A4242424242424242424242;
    send(8'h4E);
    send(8'h65);
    send(8'h6F);
    send(8'h0D);
    checks++; if (bus.count !== 5'd4) begin errors++; $display("FAIL cr_count got=%0d exp=4", bus.count); end
    send(8'h0A);
    for (int i = 0; i < 11; i++) send(8'h42);
    checks++; if (bus.msg !== exp_cr) begin errors++; $display("FAIL cr_msg got=%h exp=%h", bus.msg, exp_cr); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL cr_overrun got=%b exp=0", bus.overrun); end
  endtask
`endif

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    test_reset();
    test_message();
    test_reset_mid();
    test_back_to_back();
    test_strobe_hold();
`ifdef MSG_ASSEMBLER_TERM_EN
    test_term();
`else
    test_cr_stored();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msg_assembler.md
MSG_ASSEMBLER -- requirements
Module: msg_assembler

Interface
REQ-001 Parameter N, default 8, character width in bits.
REQ-002 Parameter M, default 128, message width in bits; M SHALL be a multiple of N.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_valid  input  1  one-cycle strobe from UART RX: rx_data holds a received character.
REQ-006 rx_data  input  N  received character.
REQ-007 msg  output  M  last completed message; first character received in msg[M-1:M-N].
REQ-008 msg_valid  output  1  one-cycle pulse: msg has just been updated.
REQ-009 count  output  $clog2(M/N)+1  characters held in the working buffer.
REQ-010 overrun  output  1  sticky: a character was dropped.

Function
REQ-011 Block SHALL be the receive-side inverse of the message-to-byte feeder: it packs incoming characters into an M-bit message, MSB-first.
REQ-012 States SHALL be IDLE (count 0), COLLECT (0<count<M/N), and PAD (terminator padding, only when the Configuration macro is defined).
REQ-013 A character SHALL be accepted on a rising edge where rx_valid=1 in IDLE or COLLECT, and SHALL be shifted into the working buffer at position count; count increments by 1.
REQ-014 IDLE->COLLECT on the first accepted character; COLLECT->IDLE when the M/N-th character is accepted.
REQ-015 On the edge accepting the M/N-th character, msg SHALL load the full buffer (including that character) and msg_valid SHALL be 1 for exactly the following cycle; latency 1 cycle.
REQ-016 In the same edge, count SHALL return to 0 and the working buffer SHALL clear; a character arriving during the msg_valid cycle SHALL be accepted as character 0 of the next message.
REQ-017 msg SHALL hold its value until the next completion; partial messages SHALL never appear on msg.
REQ-018 rx_valid in PAD SHALL drop the character and set overrun; count and buffer SHALL be unaffected by the dropped character.
REQ-019 rx_valid is a strobe; a multi-cycle high level SHALL be treated as one character per cycle.

Reset
REQ-020 reset=1 SHALL force: state IDLE, count 0, working buffer 0, msg 0, msg_valid 0, overrun 0.
REQ-021 Reset mid-message SHALL discard the partial message without a msg_valid pulse; reset has priority over rx_valid in the same cycle.

Configuration
REQ-022 Macro MSG_ASSEMBLER_TERM_EN SHALL select early termination.
REQ-023 Defined: an accepted 0x0D (CR) in IDLE or COLLECT SHALL NOT be stored; state->PAD, which fills the remaining positions with 0x20 at one per cycle, then completes as REQ-015 (msg_valid the cycle after the last pad write). CR in IDLE yields an all-0x20 message.
REQ-024 Defined: 0x0A (LF) SHALL be silently discarded in every state, without setting overrun.
REQ-025 Undefined: PAD state and its logic SHALL be absent; CR and LF SHALL be stored as ordinary characters.

Structure
REQ-026 Package msg_pkg SHALL hold N/M defaults, the state encoding, and constants CHAR_CR=0x0D, CHAR_LF=0x0A, CHAR_PAD=0x20.
REQ-027 Single module; no sub-module is required (working buffer and FSM are in-line).

Verification
REQ-028 Send "Wake up, Neo...!" (16 chars, 1 char per 20 clk) -> after the 16th edge, msg=0x57616B652075702C204E656F2E2E2E21, msg_valid high exactly 1 cycle, count 0.
REQ-029 Send 5 chars then assert reset 1 cycle, then the 16 chars above -> no msg_valid for the partial, msg matches REQ-028 afterwards.
REQ-030 Back-to-back: 16 chars, then the next char on the msg_valid cycle -> count=1 on the following cycle, msg unchanged until the second completion.
REQ-031 TERM_EN defined: "Neo" + CR -> 13 pad cycles later msg="Neo" followed by thirteen 0x20, one msg_valid pulse; rx_valid during PAD -> overrun=1, msg unaffected.
REQ-032 TERM_EN undefined: "Neo" + CR + 12 chars -> msg contains 0x0D at byte 3; overrun stays 0.
REQ-033 rx_valid held high 16 cycles with a fixed rx_data=0x41 -> msg all 0x41, one msg_valid pulse.
